// File: rtl/sample_avg_pkg.sv
// Shared constants for the two-channel EMG/ECG moving-average block.
package sample_avg_pkg;

    localparam int   ADC_W  = 12;
    localparam logic CH_EMG = 1'b0;
    localparam logic CH_ECG = 1'b1;

endpackage : sample_avg_pkg

// File: rtl/sample_averager_avg_channel.sv
// One channel of the moving averager: ring buffer, write pointer, running sum
// and fill counter. avg_next/primed_next describe the state after this sample.
module avg_channel
    import sample_avg_pkg::*;
#(
    parameter int LOG2_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] avg_next,
    output logic             primed_next,
    output logic             primed
);

    localparam int LEN    = 1 << LOG2_LEN;
    localparam int SUM_W  = ADC_W + LOG2_LEN;
    localparam int FILL_W = LOG2_LEN + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic [ADC_W-1:0]    buf_q [LEN];
    logic [LOG2_LEN-1:0] wp_q;
    logic [LOG2_LEN-1:0] wp_d;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [SUM_W-1:0]    sum_shift;

    // The sum is always the exact total of the buffer, so SUM_W bits cannot overflow.
    always_comb begin
        sum_d       = sum_q + SUM_W'(sample) - SUM_W'(buf_q[wp_q]);
        wp_d        = wp_q + LOG2_LEN'(1);
        fill_d      = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        sum_shift   = sum_d >> LOG2_LEN;
        avg_next    = sum_shift[ADC_W-1:0];
        primed_next = (fill_d == FILL_FULL);
    end

    assign primed = (fill_q == FILL_FULL);

    // NOTE: the buffer itself is reset, not only the sum: a stale entry would be
    // subtracted from the fresh sum when its slot is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) begin
                buf_q[i] <= '0;
            end
            wp_q   <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (clear) begin
            for (int i = 0; i < LEN; i++) begin
                buf_q[i] <= '0;
            end
            wp_q   <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (accept) begin
            buf_q[wp_q] <= sample;
            wp_q        <= wp_d;
            fill_q      <= fill_d;
            sum_q       <= sum_d;
        end
    end

endmodule : avg_channel

// File: rtl/sample_averager.sv
// Two-channel (EMG/ECG) moving averager with registered outputs and an optional
// ECG beat detector built only when SAMPLE_AVERAGER_BEAT_EN is defined.
module sample_averager
    import sample_avg_pkg::*;
#(
    parameter int               LOG2_LEN    = 3,
    parameter logic [ADC_W-1:0] BEAT_THRESH = 12'hA00,
    parameter int               REFRACT     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_chan,
    input  logic [31:0] in_data,
    input  logic        clear,
    output logic [31:0] emg_avg,
    output logic [31:0] ecg_avg,
    output logic        out_valid,
    output logic        out_chan,
    output logic        emg_primed,
    output logic        ecg_primed,
    output logic        beat_pulse
);

    logic [1:0]       rst_sync_q;
    logic             rst_n_sync;
    logic             accept;
    logic             emg_acc;
    logic             ecg_acc;
    logic [ADC_W-1:0] sample;
    logic [ADC_W-1:0] emg_avg_nx;
    logic [ADC_W-1:0] ecg_avg_nx;
    logic             emg_primed_nx;
    logic             ecg_primed_nx;
    logic [ADC_W-1:0] emg_avg_q;
    logic [ADC_W-1:0] ecg_avg_q;
    logic             out_valid_q;
    logic             out_chan_q;
    logic             unused_sink;

    // Reset asserts immediately but releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_sync_q[1];

    assign accept  = in_valid && !clear;
    assign emg_acc = accept && (in_chan == CH_EMG);
    assign ecg_acc = accept && (in_chan == CH_ECG);
    assign sample  = in_data[ADC_W-1:0];

    avg_channel #(.LOG2_LEN(LOG2_LEN)) u_emg (
        .clk         (clk),
        .rst_n       (rst_n_sync),
        .clear       (clear),
        .accept      (emg_acc),
        .sample      (sample),
        .avg_next    (emg_avg_nx),
        .primed_next (emg_primed_nx),
        .primed      (emg_primed)
    );

    avg_channel #(.LOG2_LEN(LOG2_LEN)) u_ecg (
        .clk         (clk),
        .rst_n       (rst_n_sync),
        .clear       (clear),
        .accept      (ecg_acc),
        .sample      (sample),
        .avg_next    (ecg_avg_nx),
        .primed_next (ecg_primed_nx),
        .primed      (ecg_primed)
    );

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            emg_avg_q   <= '0;
            ecg_avg_q   <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= CH_EMG;
        end else if (clear) begin
            emg_avg_q   <= '0;
            ecg_avg_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_chan_q <= in_chan;
            end
            if (emg_acc) begin
                emg_avg_q <= emg_avg_nx;
            end
            if (ecg_acc) begin
                ecg_avg_q <= ecg_avg_nx;
            end
        end
    end

`ifdef SAMPLE_AVERAGER_BEAT_EN
    localparam int REF_W = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

    logic [REF_W-1:0] refract_q;
    logic [REF_W-1:0] refract_d;
    logic             beat_q;
    logic             beat_d;

    // A beat is a rising crossing of the threshold on a full ECG window.
    always_comb begin
        beat_d = ecg_acc && ecg_primed_nx && (ecg_avg_q < BEAT_THRESH)
                 && (ecg_avg_nx >= BEAT_THRESH) && (refract_q == '0);
        refract_d = refract_q;
        if (ecg_acc) begin
            if (beat_d) begin
                refract_d = REF_W'(REFRACT);
            end else if (refract_q != '0) begin
                refract_d = refract_q - REF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            refract_q <= '0;
            beat_q    <= 1'b0;
        end else if (clear) begin
            refract_q <= '0;
            beat_q    <= 1'b0;
        end else begin
            refract_q <= refract_d;
            beat_q    <= beat_d;
        end
    end

    assign beat_pulse = beat_q;
`else
    localparam logic [ADC_W-1:0] unused_thresh  = BEAT_THRESH;
    localparam int               unused_refract = REFRACT;

    assign beat_pulse = 1'b0;
`endif

    assign unused_sink = ^{in_data[31:ADC_W], emg_primed_nx, ecg_primed_nx};

    assign emg_avg   = {{(32 - ADC_W){1'b0}}, emg_avg_q};
    assign ecg_avg   = {{(32 - ADC_W){1'b0}}, ecg_avg_q};
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule : sample_averager

// File: tb/tb_sample_averager.sv
// Self-checking bench for sample_averager: directed scenarios plus random
// traffic compared against a queue-based model of the moving average.
module tb_sample_averager;

    localparam int          LOG2_LEN    = 3;
    localparam int          LEN         = 1 << LOG2_LEN;
    localparam logic [11:0] BEAT_THRESH = 12'hA00;
    localparam int          REFRACT     = 16;
`ifdef SAMPLE_AVERAGER_BEAT_EN
    localparam bit BEAT_ON = 1'b1;
`else
    localparam bit BEAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_chan;
    logic [31:0] in_data;
    logic        clear;
    logic [31:0] emg_avg;
    logic [31:0] ecg_avg;
    logic        out_valid;
    logic        out_chan;
    logic        emg_primed;
    logic        ecg_primed;
    logic        beat_pulse;

    sample_averager #(
        .LOG2_LEN    (LOG2_LEN),
        .BEAT_THRESH (BEAT_THRESH),
        .REFRACT     (REFRACT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_chan    (in_chan),
        .in_data    (in_data),
        .clear      (clear),
        .emg_avg    (emg_avg),
        .ecg_avg    (ecg_avg),
        .out_valid  (out_valid),
        .out_chan   (out_chan),
        .emg_primed (emg_primed),
        .ecg_primed (ecg_primed),
        .beat_pulse (beat_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the last LEN samples of each channel (missing ones count as 0).
    int          emg_hist[$];
    int          ecg_hist[$];
    int          cnt [2];
    logic [31:0] exp_avg [2];
    logic        exp_valid;
    logic        exp_chan;
    logic        exp_beat;
    int          since_beat;
    int          beats_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsum(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_reset();
        emg_hist.delete();
        ecg_hist.delete();
        cnt        = '{0, 0};
        exp_avg    = '{32'h0, 32'h0};
        exp_valid  = 1'b0;
        exp_chan   = 1'b0;
        exp_beat   = 1'b0;
        since_beat = REFRACT;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".out_chan"}, 32'(out_chan), 32'(exp_chan));
        check({tag, ".emg_avg"}, emg_avg, exp_avg[0]);
        check({tag, ".ecg_avg"}, ecg_avg, exp_avg[1]);
        check({tag, ".emg_primed"}, 32'(emg_primed), 32'(cnt[0] >= LEN));
        check({tag, ".ecg_primed"}, 32'(ecg_primed), 32'(cnt[1] >= LEN));
        check({tag, ".beat_pulse"}, 32'(beat_pulse), 32'(exp_beat));
    endtask

    // One clock of stimulus; the model advances and everything is compared 1ns after the edge.
    task automatic step(input string tag, input logic v, input logic ch,
                        input logic [11:0] d, input logic clr);
        logic [31:0] new_avg;
        in_valid = v;
        in_chan  = v ? ch : 1'($urandom_range(0, 1));
        in_data  = ($urandom() & 32'hFFFF_F000) | 32'(d);
        clear    = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            emg_hist.delete();
            ecg_hist.delete();
            cnt        = '{0, 0};
            exp_avg    = '{32'h0, 32'h0};
            exp_valid  = 1'b0;
            exp_beat   = 1'b0;
            since_beat = REFRACT;
        end else if (v) begin
            if (ch) begin
                ecg_hist.push_back(int'(d));
                if (ecg_hist.size() > LEN) void'(ecg_hist.pop_front());
                new_avg = 32'(qsum(ecg_hist) / LEN);
            end else begin
                emg_hist.push_back(int'(d));
                if (emg_hist.size() > LEN) void'(emg_hist.pop_front());
                new_avg = 32'(qsum(emg_hist) / LEN);
            end
            cnt[ch] = cnt[ch] + 1;
            exp_beat = BEAT_ON && ch && (cnt[1] >= LEN)
                       && (exp_avg[1] < 32'(BEAT_THRESH)) && (new_avg >= 32'(BEAT_THRESH))
                       && (since_beat >= REFRACT);
            if (ch) since_beat = exp_beat ? 0 : since_beat + 1;
            exp_avg[ch] = new_avg;
            exp_valid   = 1'b1;
            exp_chan    = ch;
        end else begin
            exp_valid = 1'b0;
            exp_beat  = 1'b0;
        end
        if (beat_pulse) beats_seen++;
        check_all(tag);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        int b0;
        in_valid = 1'b0;
        in_chan  = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        beats_seen = 0;
        model_reset();

        // Power-on reset: outputs are zero before any clock edge.
        rst_n = 1'b0;
        #3;
        check_all("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 12'h0, 1'b0);

        // Eight EMG samples of 0x800: ramp 0x100 .. 0x800, primed with the 8th.
        step("emg1", 1'b1, 1'b0, 12'h800, 1'b0);
        check("emg_first_avg", emg_avg, 32'h100);
        for (int i = 1; i < LEN; i++) begin
            check("emg_not_primed", 32'(emg_primed), 32'h0);
            step("emg_ramp", 1'b1, 1'b0, 12'h800, 1'b0);
        end
        check("emg_full_avg", emg_avg, 32'h800);
        check("emg_primed_8th", 32'(emg_primed), 32'h1);
        check("ecg_still_zero", ecg_avg, 32'h0);

        // Oldest sample is replaced.
        step("wrap", 1'b1, 1'b0, 12'h000, 1'b0);
        check("wrap_avg", emg_avg, 32'h700);

        // Alternating channels every cycle, no gaps.
        for (int i = 0; i < 16; i++) begin
            step("alt", 1'b1, 1'(i % 2), (i % 2) ? 12'hFFF : 12'h400, 1'b0);
            check("alt_chan", 32'(out_chan), 32'(i % 2));
        end
        check("alt_emg_final", emg_avg, 32'h400);
        check("alt_ecg_final", ecg_avg, 32'hFFF);

        // clear wins over a simultaneous sample.
        step("clear", 1'b1, 1'b1, 12'hABC, 1'b1);
        check("clear_valid", 32'(out_valid), 32'h0);
        check("clear_emg", emg_avg, 32'h0);
        check("clear_ecg", ecg_avg, 32'h0);
        check("clear_primed", 32'({emg_primed, ecg_primed}), 32'h0);

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            logic [11:0] d;
            case ($urandom_range(0, 3))
                0:       d = 12'h000;
                1:       d = 12'hFFF;
                default: d = 12'($urandom_range(0, 4095));
            endcase
            step("rand", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), d,
                 $urandom_range(0, 79) == 0);
        end

        // Beat detector: crossing, blocked re-crossing, later crossing.
        step("beat_clr", 1'b0, 1'b0, 12'h0, 1'b1);
        for (int i = 0; i < LEN; i++) step("beat_base", 1'b1, 1'b1, 12'h000, 1'b0);
        b0 = beats_seen;
        for (int i = 0; i < LEN; i++) step("beat_ramp1", 1'b1, 1'b1, 12'hC00, 1'b0);
        check("beat_phase1", 32'(beats_seen - b0), 32'(BEAT_ON ? 1 : 0));
        b0 = beats_seen;
        for (int i = 0; i < LEN; i++) step("beat_fall2", 1'b1, 1'b1, 12'h000, 1'b0);
        for (int i = 0; i < LEN - 1; i++) step("beat_ramp2", 1'b1, 1'b1, 12'hC00, 1'b0);
        check("beat_refractory", 32'(beats_seen - b0), 32'h0);
        b0 = beats_seen;
        for (int i = 0; i < LEN; i++) step("beat_fall3", 1'b1, 1'b1, 12'h000, 1'b0);
        for (int i = 0; i < LEN; i++) step("beat_ramp3", 1'b1, 1'b1, 12'hC00, 1'b0);
        check("beat_phase3", 32'(beats_seen - b0), 32'(BEAT_ON ? 1 : 0));

        // Reset mid-window clears everything asynchronously.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'($urandom_range(0, 1)), 12'h9A5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst_idle", 1'b0, 1'b0, 12'h0, 1'b0);
        step("post_rst", 1'b1, 1'b0, 12'h800, 1'b0);
        check("post_rst_avg", emg_avg, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sample_averager
